i2c_xfer_sequencer: RTL and testbench

//  Transaction-level controller for the byte-level I2C master engine on the PCLK domain.

---
 rtl/i2c_xfer_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_xfer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_xfer_sequencer
//   Transaction-level controller in front of a byte-level I2C master engine.
//   Takes one register-access request (1-byte write, or 1-byte read using a
//   repeated start), issues the engine command sequence, checks ACK/NACK,
//   supervises every command with a timeout and returns a status per request.
//
// Ports
//   PCLK, PRESETN      clock (rising edge), async active-low reset
//   req_*              request handshake: rnw, 7-bit device, register, wdata
//   rsp_valid          one-cycle completion pulse; rsp_rdata/rsp_err hold
//                      until the next accepted request
//   rsp_err            00 ok, 01 address NACK, 10 reg/data NACK, 11 timeout
//   busy               accept through the rsp_valid cycle
//   eng_cmd_*          command to engine (op 0 START, 1 WRITE, 2 READ,
//                      3 STOP, 4 RESTART), held until eng_cmd_ready
//   eng_done/nack/rdata   engine completion, sampled only while waiting
//   eng_abort          one-cycle pulse when a command times out
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | ready for a request
// S_START   | START condition
// S_DEVW    | WRITE device address with R/W=0
// S_REG     | WRITE register address
// S_WDATA   | WRITE data byte (write request only)
// S_RESTART | repeated START (read request only)
// S_DEVR    | WRITE device address with R/W=1
// S_RDATA   | READ one byte, master NACKs
// S_STOP    | STOP condition
// S_RESP    | rsp_valid pulse, then back to idle
// Every command state has an issue phase (wait_q=0) and a wait phase (wait_q=1).
// ---------------------------------------------------------------------------
module i2c_xfer_sequencer #(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       busy,
    output logic       eng_cmd_valid,
    output logic [2:0] eng_cmd_op,
    output logic [7:0] eng_cmd_data,
    input  logic       eng_cmd_ready,
    input  logic       eng_done,
    input  logic       eng_nack,
    input  logic [7:0] eng_rdata,
    output logic       eng_abort
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_REG, S_WDATA,
        S_RESTART, S_DEVR, S_RDATA, S_STOP, S_RESP
    } state_t;

    localparam logic [2:0] OP_START   = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_READ    = 3'd2;
    localparam logic [2:0] OP_STOP    = 3'd3;
    localparam logic [2:0] OP_RESTART = 3'd4;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ADDR    = 2'b01;
    localparam logic [1:0] ERR_DATA    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            wait_q, wait_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            rnw_q, rnw_d;
    logic [6:0]      dev_q, dev_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic            is_cmd;

    assign is_cmd = (state_q != S_IDLE) && (state_q != S_RESP);

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rnw_d   = req_rnw;
                    dev_d   = req_dev;
                    reg_d   = req_reg;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = ERR_OK;
                    wait_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                if (!wait_q) begin
                    // eng_done is not looked at here, so a done coincident
                    // with the handshake is dropped.
                    if (eng_cmd_ready) begin
                        wait_d = 1'b1;
                        cnt_d  = '0;
                    end
                end else if (eng_done) begin
                    // A done arriving in the last allowed cycle still wins
                    // over the timeout.
                    wait_d = 1'b0;
                    cnt_d  = '0;
                    case (state_q)
                        S_START:   state_d = S_DEVW;
                        S_DEVW:    state_d = eng_nack ? S_STOP : S_REG;
                        S_REG:     state_d = eng_nack ? S_STOP :
                                             (rnw_q ? S_RESTART : S_WDATA);
                        S_WDATA:   state_d = S_STOP;
                        S_RESTART: state_d = S_DEVR;
                        S_DEVR:    state_d = eng_nack ? S_STOP : S_RDATA;
                        S_RDATA:   state_d = S_STOP;
                        default:   state_d = S_RESP;
                    endcase
                    if (eng_nack && err_q == ERR_OK) begin
                        if (state_q == S_DEVW || state_q == S_DEVR)
                            err_d = ERR_ADDR;
                        else if (state_q == S_REG || state_q == S_WDATA)
                            err_d = ERR_DATA;
                    end
                    if (state_q == S_RDATA)
                        rdata_d = eng_rdata;
                end else if (cnt_q == TO_LAST) begin
                    // Engine presumed hung: abort and report without a STOP.
                    wait_d  = 1'b0;
                    cnt_d   = '0;
                    rdata_d = '0;
                    state_d = S_RESP;
                    if (err_q == ERR_OK)
                        err_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        req_ready     = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        rsp_valid     = (state_q == S_RESP);
        rsp_rdata     = rdata_q;
        rsp_err       = err_q;
        eng_cmd_valid = is_cmd && !wait_q;
        eng_abort     = is_cmd && wait_q && !eng_done && (cnt_q == TO_LAST);
        eng_cmd_op    = OP_START;
        eng_cmd_data  = '0;
        if (eng_cmd_valid) begin
            case (state_q)
                S_DEVW: begin
                    eng_cmd_op   = OP_WRITE;
                    eng_cmd_data = {dev_q, 1'b0};
                end
                S_REG: begin
                    eng_cmd_op   = OP_WRITE;
                    eng_cmd_data = reg_q;
                end
                S_WDATA: begin
                    eng_cmd_op   = OP_WRITE;
                    eng_cmd_data = wdata_q;
                end
                S_RESTART: eng_cmd_op = OP_RESTART;
                S_DEVR: begin
                    eng_cmd_op   = OP_WRITE;
                    eng_cmd_data = {dev_q, 1'b1};
                end
                S_RDATA:   eng_cmd_op = OP_READ;
                S_STOP:    eng_cmd_op = OP_STOP;
                default:   eng_cmd_op = OP_START;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
`timescale 1ns/1ps
module tb_i2c_xfer_sequencer;

    localparam int TIMEOUT = 100;
    localparam int BUDGET  = 3000;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rnw = 1'b0;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       busy;
    logic       eng_cmd_valid;
    logic [2:0] eng_cmd_op;
    logic [7:0] eng_cmd_data;
    logic       eng_cmd_ready = 1'b0;
    logic       eng_done = 1'b0;
    logic       eng_nack = 1'b0;
    logic [7:0] eng_rdata = '0;
    logic       eng_abort;

    always #5 PCLK = ~PCLK;

    i2c_xfer_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .eng_cmd_valid(eng_cmd_valid), .eng_cmd_op(eng_cmd_op),
        .eng_cmd_data(eng_cmd_data), .eng_cmd_ready(eng_cmd_ready),
        .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata),
        .eng_abort(eng_abort)
    );

    typedef logic [10:0] cmd_t;   // {op, data}

    typedef struct {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] rb;
        int         nack_pos;   // command index where the engine NACKs
        int         hang_pos;   // command index whose done never comes
        int         rst_pos;    // command index where reset is pulsed
        int         ready_lat;
        int         done_lat;
        logic       early;      // also pulse done in the handshake cycle
        logic [1:0] exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   vec_no = 0;
    cmd_t exp_ops[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL v%0d %s: got 0x%0h, expected 0x%0h", vec_no, name, act, exp);
    endtask

    // Reference: expected command stream, status and read byte of one request
    task automatic model(input vec_t v, output logic [1:0] err, output logic [7:0] rdata);
        cmd_t full[$];
        int c, p;
        exp_ops.delete();
        full.push_back({3'd0, 8'h00});
        full.push_back({3'd1, v.dev, 1'b0});
        full.push_back({3'd1, v.rg});
        if (v.rnw) begin
            full.push_back({3'd4, 8'h00});
            full.push_back({3'd1, v.dev, 1'b1});
            full.push_back({3'd2, 8'h00});
        end else begin
            full.push_back({3'd1, v.wd});
        end
        full.push_back({3'd3, 8'h00});
        err = 2'b00; rdata = 8'h00; c = 0; p = 0;
        while (c < full.size()) begin
            exp_ops.push_back(full[c]);
            if (p == v.hang_pos) begin
                if (err == 2'b00) err = 2'b11;
                break;
            end
            if (p == v.nack_pos && full[c][10:8] == 3'd1) begin
                if (err == 2'b00) err = (c == 1 || c == 4) ? 2'b01 : 2'b10;
                c = full.size() - 1;
            end else begin
                if (full[c][10:8] == 3'd2) rdata = v.rb;
                c++;
            end
            p++;
        end
        if (err != 2'b00) rdata = 8'h00;
    endtask

    function automatic logic [25:0] out_vec();
        return {req_ready, busy, rsp_valid, eng_cmd_valid, eng_cmd_op, eng_cmd_data,
                rsp_rdata, rsp_err, eng_abort};
    endfunction

    localparam logic [25:0] RESET_OUTS = {1'b1, 25'd0};

    task automatic run_vec(input vec_t v);
        cmd_t       obs[$];
        logic [1:0] m_err;
        logic [7:0] m_rdata;
        int         phase, wcnt, stall, idx, cyc, abort_cnt, abort_w, unstable, stray, mi, rsp_seen;
        logic       new_cmd, saw_rsp, fin, rst_fire, found;
        logic [2:0] hold_op;
        logic [7:0] hold_data;
        logic [1:0] got_err, post_err;
        logic [7:0] got_rdata;
        logic       rsp_busy, post_ready, post_rspv;

        model(v, m_err, m_rdata);
        phase = 0; wcnt = 0; stall = 0; idx = 0; cyc = 0; abort_cnt = 0; abort_w = 0;
        unstable = 0; stray = 0; rsp_seen = 0;
        new_cmd = 1'b1; saw_rsp = 1'b0; fin = 1'b0; rst_fire = 1'b0;
        hold_op = '0; hold_data = '0; got_err = '0; post_err = '0; got_rdata = '0;
        rsp_busy = 1'b0; post_ready = 1'b0; post_rspv = 1'b1;

        @(negedge PCLK);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_rnw = v.rnw; req_dev = v.dev; req_reg = v.rg; req_wdata = v.wd;
        @(negedge PCLK);
        // scrambled request fields after accept must not matter
        req_valid = 1'b0; req_rnw = 1'($urandom); req_dev = 7'($urandom);
        req_reg = 8'($urandom); req_wdata = 8'($urandom);
        check("busy_after_accept", {30'd0, req_ready, busy}, 32'd1);

        while (!fin && cyc < BUDGET) begin
            eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'($urandom);
            if (saw_rsp) begin
                fin = 1'b1; post_ready = req_ready; post_rspv = rsp_valid; post_err = rsp_err;
            end else if (rsp_valid) begin
                saw_rsp = 1'b1; rsp_seen++;
                got_err = rsp_err; got_rdata = rsp_rdata; rsp_busy = busy;
            end
            if (phase == 1) wcnt++;
            if (eng_abort) begin
                abort_cnt++;
                abort_w = (phase == 1) ? wcnt : -1;
                phase = 0; new_cmd = 1'b1; eng_cmd_ready = 1'b0;
            end else if (phase == 0) begin
                if (eng_cmd_valid) begin
                    if (new_cmd) begin
                        obs.push_back({eng_cmd_op, eng_cmd_data});
                        hold_op = eng_cmd_op; hold_data = eng_cmd_data;
                        new_cmd = 1'b0; stall = 0;
                    end else if (eng_cmd_op !== hold_op || eng_cmd_data !== hold_data) begin
                        unstable++;
                    end
                    if (stall >= v.ready_lat) begin
                        eng_cmd_ready = 1'b1; phase = 1; wcnt = 0;
                        if (v.early) eng_done = 1'b1;
                    end else begin
                        eng_cmd_ready = 1'b0; stall++;
                    end
                end else begin
                    eng_cmd_ready = 1'b0;
                end
            end else begin
                eng_cmd_ready = 1'b0;
                if (eng_cmd_valid) stray++;
                if (idx == v.rst_pos) begin
                    rst_fire = 1'b1;
                end else if (idx != v.hang_pos && wcnt == v.done_lat) begin
                    eng_done = 1'b1;
                    eng_nack = (idx == v.nack_pos);
                    if (hold_op == 3'd2) eng_rdata = v.rb;
                    phase = 0; new_cmd = 1'b1; idx++;
                end
            end
            if (rst_fire) break;
            cyc++;
            if (!fin) @(negedge PCLK);
        end
        eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;

        if (rst_fire) begin
            PRESETN = 1'b0;
            #1;
            check("reset_outputs_async", {6'd0, out_vec()}, {6'd0, RESET_OUTS});
            check("reset_rdata_cleared", {24'd0, rsp_rdata}, 32'd0);
            @(negedge PCLK);
            check("reset_outputs_held", {6'd0, out_vec()}, {6'd0, RESET_OUTS});
            PRESETN = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge PCLK);
                if (rsp_valid || eng_cmd_valid || !req_ready) rsp_seen++;
            end
            check("post_reset_quiet", rsp_seen, 32'd0);
            return;
        end

        check("finished_in_budget", {31'd0, fin}, 32'd1);
        check("ops_count", obs.size(), exp_ops.size());
        mi = 0; found = 1'b0;
        for (int k = 0; k < obs.size() && k < exp_ops.size(); k++)
            if (!found && obs[k] !== exp_ops[k]) begin mi = k; found = 1'b1; end
        if (obs.size() > 0 && exp_ops.size() > 0)
            check("ops_seq", {21'd0, obs[mi]}, {21'd0, exp_ops[mi]});
        check("rsp_err", {30'd0, got_err}, {30'd0, v.exp_err});
        check("rsp_rdata", {24'd0, got_rdata}, {24'd0, v.exp_rdata});
        check("busy_in_resp", {31'd0, rsp_busy}, 32'd1);
        check("rsp_single_pulse", {30'd0, post_rspv, post_ready}, 32'd1);
        check("rsp_err_hold", {30'd0, post_err}, {30'd0, got_err});
        check("abort_count", abort_cnt, (v.hang_pos >= 0) ? 32'd1 : 32'd0);
        if (v.hang_pos >= 0) check("abort_wait_cycle", abort_w, TIMEOUT);
        check("cmd_stable", unstable, 32'd0);
        check("no_valid_in_wait", stray, 32'd0);
    endtask

    function automatic vec_t mk(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input logic [7:0] rb,
                                input int nack, input int hang, input int rst,
                                input int rl, input int dl, input logic early,
                                input logic [1:0] ee, input logic [7:0] er);
        vec_t v;
        v.rnw = rnw; v.dev = dev; v.rg = rg; v.wd = wd; v.rb = rb;
        v.nack_pos = nack; v.hang_pos = hang; v.rst_pos = rst;
        v.ready_lat = rl; v.done_lat = dl; v.early = early;
        v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks done", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        vec_t       r;
        logic [1:0] e;
        logic [7:0] d;
        int         len, kind;

        //            rnw   dev    reg    wdata  rbyte  nack hang rst rl  dl  early err    rdata
        tbl[0]  = mk(1'b0, 7'h50, 8'h12, 8'hD0, 8'h00, -1, -1, -1, 0,   3, 1'b0, 2'b00, 8'h00);
        tbl[1]  = mk(1'b1, 7'h68, 8'h34, 8'h00, 8'hAB, -1, -1, -1, 0,   3, 1'b0, 2'b00, 8'hAB);
        tbl[2]  = mk(1'b0, 7'h50, 8'h12, 8'hD0, 8'h00,  1, -1, -1, 0,   2, 1'b0, 2'b01, 8'h00);
        tbl[3]  = mk(1'b1, 7'h68, 8'h34, 8'h00, 8'hAB,  2, -1, -1, 1,   2, 1'b0, 2'b10, 8'h00);
        tbl[4]  = mk(1'b1, 7'h68, 8'h34, 8'h00, 8'hAB, -1,  5, -1, 0,   2, 1'b0, 2'b11, 8'h00);
        tbl[5]  = mk(1'b1, 7'h2A, 8'h55, 8'h00, 8'h3C, -1, -1, -1, 20,  5, 1'b0, 2'b00, 8'h3C);
        tbl[6]  = mk(1'b0, 7'h11, 8'h22, 8'h33, 8'h00, -1, -1, -1, 150, 2, 1'b0, 2'b00, 8'h00);
        tbl[7]  = mk(1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00,  3, -1, -1, 0,   4, 1'b0, 2'b10, 8'h00);
        tbl[8]  = mk(1'b1, 7'h01, 8'h00, 8'h00, 8'h99,  4, -1, -1, 2,   3, 1'b0, 2'b01, 8'h00);
        tbl[9]  = mk(1'b1, 7'h33, 8'h44, 8'h00, 8'hC3,  6, -1, -1, 0,   2, 1'b0, 2'b00, 8'hC3);
        tbl[10] = mk(1'b1, 7'h33, 8'h45, 8'h00, 8'h5A,  5, -1, -1, 0,   2, 1'b0, 2'b00, 8'h5A);
        tbl[11] = mk(1'b0, 7'h20, 8'h01, 8'h02, 8'h00, -1,  0, -1, 0,   2, 1'b0, 2'b11, 8'h00);
        tbl[12] = mk(1'b0, 7'h21, 8'h02, 8'h03, 8'h00, -1, -1, -1, 0,   1, 1'b1, 2'b00, 8'h00);
        tbl[13] = mk(1'b0, 7'h22, 8'h03, 8'h04, 8'h00, -1, -1, -1, 0,  99, 1'b0, 2'b00, 8'h00);
        tbl[14] = mk(1'b1, 7'h68, 8'h34, 8'h00, 8'hE7, -1, -1,  6, 0,   2, 1'b0, 2'b00, 8'h00);
        tbl[15] = mk(1'b1, 7'h68, 8'h34, 8'h00, 8'h42, -1, -1, -1, 0,   2, 1'b0, 2'b00, 8'h42);

        PRESETN = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset_state", {6'd0, out_vec()}, {6'd0, RESET_OUTS});
        PRESETN = 1'b1;

        for (int i = 0; i < 16; i++) begin
            vec_no = i;
            run_vec(tbl[i]);
        end

        for (int i = 0; i < 40; i++) begin
            vec_no = 100 + i;
            r = mk(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   -1, -1, -1, 0, 1, 1'b0, 2'b00, 8'h00);
            len  = r.rnw ? 7 : 5;
            kind = $urandom_range(0, 9);
            if (kind < 3)       r.nack_pos = $urandom_range(0, len - 1);
            else if (kind == 3) r.hang_pos = $urandom_range(0, len - 1);
            r.ready_lat = $urandom_range(0, 4);
            r.done_lat  = $urandom_range(1, 8);
            model(r, e, d);
            r.exp_err = e; r.exp_rdata = d;
            run_vec(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
